// File: rtl/ram16k_arbiter.sv
// Two-requester round-robin arbiter in front of a single RAM16K.
// Each access takes one arbitration cycle (IDLE) and one access cycle (ACCESS).
// A requester may hold its grant with rN_lock for up to MAX_BURST grants in a row.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_req/we/addr/wdata/lock  command from requester N (0 = CPU, 1 = DMA)
//   rN_ack                     one-cycle completion pulse to requester N
//   rN_rdata                   RAM read data, valid while rN_ack=1, else 0
//   ram_in/ram_load/ram_address/ram_out  RAM16K interface
module ram16k_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BURST_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [13:0] r0_addr,
  input  logic [15:0] r0_wdata,
  input  logic        r0_lock,
  output logic        r0_ack,
  output logic [15:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [13:0] r1_addr,
  input  logic [15:0] r1_wdata,
  input  logic        r1_lock,
  output logic        r1_ack,
  output logic [15:0] r1_rdata,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic [13:0] ram_address,
  input  logic [15:0] ram_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state;
  logic               owner;
  logic               last;
  logic               locked;
  logic [BURST_W-1:0] burst_cnt;

  logic lock_keep;
  logic grant_valid;
  logic winner;
  logic owner_lock;
  logic burst_room;

  // Arbitration: a live lock pins the grant to the owner, otherwise round-robin.
  always_comb begin
    lock_keep   = locked && (owner ? r1_req : r0_req);
    grant_valid = 1'b0;
    winner      = 1'b0;
    if (lock_keep) begin
      grant_valid = 1'b1;
      winner      = owner;
    end else if (r0_req && r1_req) begin
      grant_valid = 1'b1;
      winner      = ~last;
    end else if (r0_req) begin
      grant_valid = 1'b1;
      winner      = 1'b0;
    end else if (r1_req) begin
      grant_valid = 1'b1;
      winner      = 1'b1;
    end
  end

  assign owner_lock = owner ? r1_lock : r0_lock;
  assign burst_room = burst_cnt < BURST_W'(MAX_BURST - 1);

  // ram_load and the acks are only ever high in ACCESS, so reset kills a pending write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      locked      <= 1'b0;
      burst_cnt   <= '0;
      ram_load    <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Owner walked away from its lock: release it and arbitrate normally now.
          if (locked && !lock_keep) begin
            locked    <= 1'b0;
            burst_cnt <= '0;
          end
          if (grant_valid) begin
            state       <= ACCESS;
            owner       <= winner;
            last        <= winner;
            ram_address <= winner ? r1_addr  : r0_addr;
            ram_in      <= winner ? r1_wdata : r0_wdata;
            ram_load    <= winner ? r1_we    : r0_we;
            r0_ack      <= ~winner;
            r1_ack      <= winner;
          end
        end
        ACCESS: begin
          state    <= IDLE;
          ram_load <= 1'b0;
          r0_ack   <= 1'b0;
          r1_ack   <= 1'b0;
          if (owner_lock && burst_room) begin
            locked    <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            locked    <= 1'b0;
            burst_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read is combinational, so read data is steered straight through during the ack cycle.
  assign r0_rdata = r0_ack ? ram_out : 16'h0000;
  assign r1_rdata = r1_ack ? ram_out : 16'h0000;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Testbench for ram16k_arbiter: randomized and directed traffic from two
// requester agents, checked every cycle against a transaction-level model.
module tb_ram16k_arbiter;

  localparam int unsigned MAX_BURST = 4;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic        lock;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r0_lock, r0_ack;
  logic [13:0] r0_addr;
  logic [15:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_lock, r1_ack;
  logic [13:0] r1_addr;
  logic [15:0] r1_wdata, r1_rdata;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;
  logic [13:0] ram_address;

  ram16k_arbiter #(.MAX_BURST(MAX_BURST), .BURST_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_lock(r0_lock), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // RAM16K: synchronous write, combinational read
  logic [15:0] ram_mem [16384];
  assign ram_out = ram_mem[ram_address];
  always @(posedge clk) if (ram_load) ram_mem[ram_address] <= ram_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model: transaction level
  bit          m_access, m_owner, m_last, m_hold;
  int          m_run;
  logic        exp_we;
  logic [13:0] exp_addr;
  logic [15:0] exp_wdata;
  logic [15:0] refmem [16384];
  bit          written [16384];

  // Agents
  cmd_t q0[$], q1[$];
  bit   act0, act1, seen0, seen1;
  bit   rnd_mode, refill, hook_push0;
  int   hook_cyc;
  int   cyc;
  int   log_owner[$], log_cyc[$];
  int   load_cnt;
  logic [15:0] last_rd0, last_rd1;
  bit   kill_on_ack0, killed;

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.wdata = 16'($urandom);
    c.lock  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       c.addr = 14'h3FFF;
      1:       c.addr = 14'($urandom);
      default: c.addr = 14'($urandom_range(0, 7));
    endcase
    return c;
  endfunction

  function automatic cmd_t mk(input bit we, input int addr, input int data, input bit lock);
    cmd_t c;
    c.we = we; c.addr = 14'(addr); c.wdata = 16'(data); c.lock = lock;
    return c;
  endfunction

  task automatic model_reset();
    m_access = 0; m_owner = 0; m_last = 1; m_hold = 0; m_run = 0;
    exp_we = 0; exp_addr = '0; exp_wdata = '0;
  endtask

  // One clock edge of the spec rules: arbitrate in idle, close the access otherwise.
  task automatic model_edge();
    bit rq0, rq1, have, w, lk;
    if (m_access) begin
      if (exp_we) begin
        refmem[exp_addr]  = exp_wdata;
        written[exp_addr] = 1'b1;
      end
      lk = m_owner ? r1_lock : r0_lock;
      m_hold   = lk && (m_run < int'(MAX_BURST));
      m_access = 0;
    end else begin
      rq0 = r0_req; rq1 = r1_req;
      if (m_hold && !(m_owner ? rq1 : rq0)) m_hold = 0;
      have = 1; w = 0;
      if (m_hold)           w = m_owner;
      else if (rq0 && rq1)  w = !m_last;
      else if (rq0)         w = 0;
      else if (rq1)         w = 1;
      else                  have = 0;
      if (have) begin
        m_run     = (m_hold && w == m_owner) ? m_run + 1 : 1;
        m_owner   = w;
        m_last    = w;
        m_access  = 1;
        exp_we    = w ? r1_we    : r0_we;
        exp_addr  = w ? r1_addr  : r0_addr;
        exp_wdata = w ? r1_wdata : r0_wdata;
      end
    end
  endtask

  task automatic drive();
    if (seen0) begin q0.delete(0); act0 = 0; end
    if (seen1) begin q1.delete(0); act1 = 0; end
    seen0 = 0; seen1 = 0;
    if (hook_push0 && q1.size() == 0) begin
      q0.push_back(mk(0, 1, 0, 0));
      hook_push0 = 0;
      hook_cyc   = cyc;
    end
    if (refill && q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_cmd());
    if (refill && q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_cmd());
    if (!act0 && q0.size() != 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) act0 = 1;
    if (!act1 && q1.size() != 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) act1 = 1;
    r0_req = act0;
    r1_req = act1;
    if (act0) {r0_we, r0_addr, r0_wdata, r0_lock} = q0[0];
    else      {r0_we, r0_addr, r0_wdata, r0_lock} = 32'($urandom);
    if (act1) {r1_we, r1_addr, r1_wdata, r1_lock} = q1[0];
    else      {r1_we, r1_addr, r1_wdata, r1_lock} = 32'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load"}, 32'(ram_load), 0);
    chk({tag, "_addr"}, 32'(ram_address), 0);
    chk({tag, "_in"},   32'(ram_in), 0);
    chk({tag, "_ack0"}, 32'(r0_ack), 0);
    chk({tag, "_ack1"}, 32'(r1_ack), 0);
    chk({tag, "_rd0"},  32'(r0_rdata), 0);
    chk({tag, "_rd1"},  32'(r1_rdata), 0);
  endtask

  task automatic clear_agents();
    q0.delete(); q1.delete();
    act0 = 0; act1 = 0; seen0 = 0; seen1 = 0;
    r0_req = 0; r1_req = 0;
  endtask

  task automatic hold_reset_and_release();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    clear_agents();
    check_reset_outputs(tag);
    hold_reset_and_release();
  endtask

  // One clock: check at negedge, model at posedge, drive just after posedge.
  task automatic cycle();
    bit o0, o1;
    @(negedge clk);
    o0 = m_access && !m_owner;
    o1 = m_access &&  m_owner;
    chk("ack0", 32'(r0_ack), 32'(o0));
    chk("ack1", 32'(r1_ack), 32'(o1));
    chk("ack_excl", 32'(r0_ack & r1_ack), 0);
    chk("ram_load", 32'(ram_load), 32'(m_access && exp_we));
    chk("ram_address", 32'(ram_address), 32'(exp_addr));
    chk("ram_in", 32'(ram_in), 32'(exp_wdata));
    if (!o0)                                  chk("rdata0_idle", 32'(r0_rdata), 0);
    else if (!exp_we && written[exp_addr])    chk("rdata0", 32'(r0_rdata), 32'(refmem[exp_addr]));
    if (!o1)                                  chk("rdata1_idle", 32'(r1_rdata), 0);
    else if (!exp_we && written[exp_addr])    chk("rdata1", 32'(r1_rdata), 32'(refmem[exp_addr]));
    if (ram_load) load_cnt++;
    seen0 = r0_ack;
    seen1 = r1_ack;
    if (r0_ack) begin
      log_owner.push_back(0); log_cyc.push_back(cyc);
      if (q0.size() != 0 && !q0[0].we) last_rd0 = r0_rdata;
    end
    if (r1_ack) begin
      log_owner.push_back(1); log_cyc.push_back(cyc);
      if (q1.size() != 0 && !q1[0].we) last_rd1 = r1_rdata;
    end
    if (kill_on_ack0 && r0_ack) begin
      chk("kill_pre_load", 32'(ram_load), 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      clear_agents();
      check_reset_outputs("kill");
      kill_on_ack0 = 0;
      killed = 1;
      return;
    end
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    drive();
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(q0.size() + q1.size()), 0);
  endtask

  task automatic check_log(input string tag, input int want[$]);
    chk({tag, "_len"}, 32'(log_owner.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < log_owner.size(); i++) begin
      chk($sformatf("%s_owner%0d", tag, i), 32'(log_owner[i]), 32'(want[i]));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 32'(log_cyc[i] - log_cyc[i-1]), 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int want[$];
    int n;
    cyc = 0; load_cnt = 0; rnd_mode = 0; refill = 0; hook_push0 = 0;
    kill_on_ack0 = 0; killed = 0; hook_cyc = 0;
    for (int i = 0; i < 16384; i++) written[i] = 1'b0;
    r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_lock = 0;
    r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_lock = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    clear_agents();
    check_reset_outputs("por");
    hold_reset_and_release();

    // r0 write 5<-3 then read back
    load_cnt = 0;
    log_owner.delete(); log_cyc.delete();
    q0.push_back(mk(1, 5, 3, 0));
    q0.push_back(mk(0, 5, 0, 0));
    run_until_empty("t1", 20);
    chk("t1_load_pulses", 32'(load_cnt), 1);
    chk("t1_acks", 32'(log_owner.size()), 2);
    chk("t1_rdata", 32'(last_rd0), 3);

    // continuous requests from reset alternate r0,r1
    do_reset("rst2");
    log_owner.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1, 16 + i, 100 + i, 0));
      q1.push_back(mk(1, 32 + i, 200 + i, 0));
    end
    run_until_empty("t2", 40);
    want = '{0, 1, 0, 1, 0, 1, 0, 1};
    check_log("rr", want);

    // r1 locked burst of 6 against a waiting r0
    do_reset("rst3");
    log_owner.delete(); log_cyc.delete();
    q0.push_back(mk(1, 40, 1, 0));
    q0.push_back(mk(1, 41, 2, 0));
    for (int i = 0; i < 6; i++) q1.push_back(mk(1, 48 + i, 300 + i, 1));
    run_until_empty("t3", 60);
    want = '{0, 1, 1, 1, 1, 0, 1, 1};
    check_log("burst", want);

    // locked r1 drops req while r0 arrives: r0 granted in that same idle cycle
    do_reset("rst4");
    log_owner.delete(); log_cyc.delete();
    q1.push_back(mk(1, 60, 7, 1));
    q1.push_back(mk(1, 61, 8, 1));
    hook_push0 = 1;
    n = 0;
    while ((hook_push0 || q0.size() != 0) && n < 30) begin cycle(); n++; end
    chk("t4_timeout", 32'(q0.size()), 0);
    want = '{1, 1, 0};
    check_log("lockdrop", want);
    if (log_cyc.size() == 3) chk("t4_latency", 32'(log_cyc[2] - hook_cyc), 1);

    // top address boundary
    q1.push_back(mk(1, 16383, 16'hFFFF, 0));
    q1.push_back(mk(0, 16383, 0, 0));
    run_until_empty("t5", 20);
    chk("t5_rdata", 32'(last_rd1), 32'hFFFF);
    chk("t5_addr", 32'(ram_address), 32'h3FFF);

    // randomized traffic
    rnd_mode = 1; refill = 1;
    repeat (800) cycle();
    refill = 0;
    run_until_empty("rnd", 200);
    rnd_mode = 0;

    // reset in the middle of a write access
    q0.push_back(mk(1, 9, 16'h1234, 0));
    run_until_empty("t6a", 20);
    q0.push_back(mk(1, 9, 7, 0));
    kill_on_ack0 = 1; killed = 0;
    n = 0;
    while (!killed && n < 20) begin cycle(); n++; end
    chk("t6_killed", 32'(killed), 1);
    kill_on_ack0 = 0;
    hold_reset_and_release();
    log_owner.delete(); log_cyc.delete();
    repeat (3) cycle();
    chk("t6_no_late_ack", 32'(log_owner.size()), 0);
    q0.push_back(mk(0, 9, 0, 0));
    run_until_empty("t6b", 20);
    chk("t6_old_value", 32'(last_rd0), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram16k_arbiter.md
Name: ram16k_arbiter

Overview:
- Two-requester arbiter sharing one RAM16K (16-bit data, 14-bit address, synchronous write on load, combinational read).
- Requester 0 is the CPU data port. Requester 1 is a DMA/screen-refresh engine.
- Round-robin arbitration, plus an optional bounded lock so one requester can run a burst.
- The block drives the RAM16K in/load/address inputs and routes the RAM out back to the owning requester.

Parameters:
- MAX_BURST, 4: maximum consecutive locked grants to one requester. Legal range 1..15.
- BURST_W, 4: width of the burst counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- r0_req  input  1  requester 0 command valid.
- r0_we  input  1  requester 0 write (1) / read (0).
- r0_addr  input  14  requester 0 address.
- r0_wdata  input  16  requester 0 write data.
- r0_lock  input  1  requester 0 requests to keep the grant after this access.
- r0_ack  output  1  requester 0 access completes this cycle.
- r0_rdata  output  16  requester 0 read data; valid while r0_ack=1.
- r1_req, r1_we, r1_addr, r1_wdata, r1_lock, r1_ack, r1_rdata: same as requester 0, for requester 1.
- ram_in  output  16  to RAM16K in.
- ram_load  output  1  to RAM16K load.
- ram_address  output  14  to RAM16K address.
- ram_out  input  16  from RAM16K out.

Behaviour:
Interface:
- One clock, clk. Reset is rst_n: asynchronous, active-low.

Reset values (immediately on rst_n=0):
- state=IDLE, ram_load=0, ram_address=0, ram_in=0.
- r0_ack=0, r1_ack=0.
- locked=0, owner=0, burst_cnt=0, last=1, so r0 wins the first tie.

FSM, two states, IDLE and ACCESS:
- IDLE, any eligible req: pick winner; register its addr/wdata/we into ram_address/ram_in/load_q; owner<=winner; last<=winner; go to ACCESS.
- IDLE, no eligible req: stay in IDLE; ram_address/ram_in hold their last values.
- ACCESS: ram_load=load_q (0 for reads). rN_ack=1 for the owner only, decoded from registered state.
- ACCESS: the RAM writes at the closing edge when ram_load=1.
- ACCESS -> IDLE unconditionally. Each access costs 2 cycles: one arbitration cycle plus one access cycle.

Eligibility and arbitration:
- Unlocked: both requesting -> grant the requester other than last. One requesting -> grant it.
- Locked: only owner is eligible. If owner req=0 in IDLE, clear locked and burst_cnt, then arbitrate normally in that same cycle.

Lock/burst, evaluated at the edge closing ACCESS:
- Owner lock=1 and burst_cnt < MAX_BURST-1: locked<=1, burst_cnt<=burst_cnt+1.
- Otherwise: locked<=0, burst_cnt<=0.
- Effect: one requester gets at most MAX_BURST consecutive grants while the other is requesting.
- MAX_BURST=1 disables locking.

Read data:
- rN_rdata = ram_out when owner=N and state=ACCESS, else 0.
- On a write access, rdata shows the pre-write content and is don't-care for the requester.

Handshake:
- Requester holds req/we/addr/wdata/lock stable until it samples rN_ack=1.
- At that same edge it either drops req or presents its next command.
- The arbiter never samples req during ACCESS.
- ack is a single-cycle pulse; it never asserts to both requesters at once.

Boundaries:
- Address 16383 is passed through unchanged; no wrap or modification.
- A simultaneous lock request from the non-owner is ignored.
- rst_n asserted during ACCESS: ram_load falls asynchronously before the next edge, so no write occurs. The pending access is dropped and no ack is issued after reset.

Test Plan:
- After reset, r0 writes addr 5 data 3 -> ram_load=1 for exactly one cycle with ram_address=5 and ram_in=3; r0_ack pulses once. r0 then reads addr 5 -> r0_rdata=3 during ack.
- r0 and r1 request continuously from reset -> grant order r0,r1,r0,r1, one ack every 2 cycles; r0_ack and r1_ack are never high together.
- MAX_BURST=4, r1_lock=1 with 6 queued r1 accesses, r0 requesting -> r1 gets 4 acks, then r0 gets 1, then r1 resumes.
- r1 locked, r1 drops req in IDLE while r0 requests -> r0 is granted in that same IDLE cycle; locked=0 and burst_cnt=0.
- r1 writes 65535 to addr 16383, then reads it -> r1_rdata=65535 and ram_address=16383.
- rst_n pulsed low mid-ACCESS of an r0 write of 7 to addr 9 -> ram_load=0 immediately; a later read of addr 9 returns the old value; all outputs are at reset values.
